// File: rtl/eth_phy_ipg_rx_extract.sv
// IPG payload extractor: packs carrier-block bytes into OUT_BYTES words behind a FWFT output FIFO.
// Optional sequence-gap tracker enabled by defining IPG_SEQ_CHECK_EN.
module eth_phy_ipg_rx_extract #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned HDR_WIDTH      = 2,
  parameter logic [7:0]  IPG_BLOCK_TYPE = 8'hD2,
  parameter int unsigned OUT_BYTES      = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [HDR_WIDTH-1:0]   in_hdr,
  input  logic                   in_valid,
  input  logic                   rx_block_lock,
  output logic [8*OUT_BYTES-1:0] m_tdata,
  output logic [OUT_BYTES-1:0]   m_tkeep,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   stat_ipg_block,
  output logic                   stat_bad_block,
  output logic                   stat_overflow,
  output logic                   stat_seq_err,
  output logic [CNT_WIDTH-1:0]   bad_count,
  output logic [CNT_WIDTH-1:0]   ovf_count,
  output logic [CNT_WIDTH-1:0]   seq_err_count
);

  localparam int unsigned OW    = 8 * OUT_BYTES;
  localparam int unsigned MAX_N = 6;
  localparam int unsigned PW    = 8 * MAX_N;
  localparam int unsigned CBW   = OW + PW;
  localparam int unsigned AW    = $clog2(OUT_BYTES + MAX_N + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW    = OW + OUT_BYTES + 1;

  logic [OW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]       mcnt_q, mcnt_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [OW-1:0]        m_tdata_q, m_tdata_d;
  logic [OUT_BYTES-1:0] m_tkeep_q, m_tkeep_d;
  logic                 m_tlast_q, m_tlast_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 stat_ipg_q, stat_bad_q, stat_ovf_q, stat_seq_q;
  logic [CNT_WIDTH-1:0] bad_count_q, bad_count_d;
  logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
  logic [CNT_WIDTH-1:0] seq_count_q, seq_count_d;

  logic                 active, is_ctrl, is_data, is_carrier;
  logic [2:0]           blk_n;
  logic                 good_blk, bad_blk, flush_req;
  logic [PW-1:0]        pay;
  logic [CBW-1:0]       merged;
  logic [AW-1:0]        sum;
  logic                 push_req, push, ovf, pop, load, fifo_full;
  logic [OW-1:0]        push_data;
  logic [OUT_BYTES-1:0] push_keep;
  logic                 push_last;
  logic                 seq_err;

  // Block classification and payload alignment behind the bytes already held
  always_comb begin
    active     = in_valid && rx_block_lock;
    is_ctrl    = in_hdr == HDR_WIDTH'(2'b01);
    is_data    = in_hdr == HDR_WIDTH'(2'b10);
    is_carrier = is_ctrl && (in_data[7:0] == IPG_BLOCK_TYPE);
    blk_n      = in_data[10:8];
    bad_blk    = active && is_carrier && (blk_n > 3'd6);
    good_blk   = active && is_carrier && (blk_n <= 3'd6);
    flush_req  = active && !is_carrier && (is_data || is_ctrl) && (acc_cnt_q != '0);
    pay = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (3'(k) < blk_n) pay[8*k +: 8] = in_data[16+8*k +: 8];
    end
    merged = CBW'(acc_q) | (CBW'(pay) << {acc_cnt_q, 3'b000});
    sum    = acc_cnt_q + AW'(blk_n);
  end

  assign fifo_full = (mcnt_q + FCW'(m_tvalid_q)) == FCW'(FIFO_DEPTH);
  assign pop       = m_tvalid_q && m_tready;
  assign load      = (!m_tvalid_q || pop) && (mcnt_q != '0);

  // Accumulator update, push request and overflow decision
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    push_req  = 1'b0;
    push_data = merged[OW-1:0];
    push_keep = '1;
    push_last = 1'b0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (flush_req) push_keep[i] = AW'(i) < acc_cnt_q;
    end
    if (!rx_block_lock) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end else if (good_blk) begin
      if (sum >= AW'(OUT_BYTES)) begin
        push_req = 1'b1;
        if (!fifo_full || pop) begin
          acc_d     = OW'(merged >> OW);
          acc_cnt_d = sum - AW'(OUT_BYTES);
        end
      end else begin
        acc_d     = merged[OW-1:0];
        acc_cnt_d = sum;
      end
    end else if (flush_req) begin
      push_req  = 1'b1;
      push_data = acc_q;
      push_last = 1'b1;
      acc_d     = '0;
      acc_cnt_d = '0;
    end
    push = push_req && (!fifo_full || pop);
    ovf  = push_req && fifo_full && !pop;
  end

  // FIFO pointers and registered head word
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(load);
    mcnt_d     = mcnt_q + FCW'(push) - FCW'(load);
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    if (load) begin
      m_tvalid_d = 1'b1;
      {m_tdata_d, m_tkeep_d, m_tlast_d} = mem_q[rd_ptr_q];
    end else if (pop) begin
      m_tvalid_d = 1'b0;
    end
  end

  // Saturating event counters
  always_comb begin
    bad_count_d = bad_count_q;
    ovf_count_d = ovf_count_q;
    seq_count_d = seq_count_q;
    if (bad_blk && (bad_count_q != '1)) bad_count_d = bad_count_q + CNT_WIDTH'(1);
    if (ovf && (ovf_count_q != '1))     ovf_count_d = ovf_count_q + CNT_WIDTH'(1);
    if (seq_err && (seq_count_q != '1)) seq_count_d = seq_count_q + CNT_WIDTH'(1);
  end

`ifdef IPG_SEQ_CHECK_EN
  logic       armed_q, armed_d;
  logic [4:0] exp_seq_q, exp_seq_d;

  // Sequence tracker: arm on first good block, resync on every good block
  always_comb begin
    armed_d   = armed_q;
    exp_seq_d = exp_seq_q;
    seq_err   = 1'b0;
    if (!rx_block_lock) begin
      armed_d = 1'b0;
    end else if (good_blk) begin
      seq_err   = armed_q && (in_data[15:11] != exp_seq_q);
      armed_d   = 1'b1;
      exp_seq_d = in_data[15:11] + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      exp_seq_q <= '0;
    end else begin
      armed_q   <= armed_d;
      exp_seq_q <= exp_seq_d;
    end
  end
`else
  logic unused_seq;
  assign unused_seq = ^in_data[15:11];
  assign seq_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_data, push_keep, push_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mcnt_q      <= '0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      stat_ipg_q  <= 1'b0;
      stat_bad_q  <= 1'b0;
      stat_ovf_q  <= 1'b0;
      stat_seq_q  <= 1'b0;
      bad_count_q <= '0;
      ovf_count_q <= '0;
      seq_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mcnt_q      <= mcnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      stat_ipg_q  <= good_blk;
      stat_bad_q  <= bad_blk;
      stat_ovf_q  <= ovf;
      stat_seq_q  <= seq_err;
      bad_count_q <= bad_count_d;
      ovf_count_q <= ovf_count_d;
      seq_count_q <= seq_count_d;
    end
  end

  assign m_tdata        = m_tdata_q;
  assign m_tkeep        = m_tkeep_q;
  assign m_tlast        = m_tlast_q;
  assign m_tvalid       = m_tvalid_q;
  assign stat_ipg_block = stat_ipg_q;
  assign stat_bad_block = stat_bad_q;
  assign stat_overflow  = stat_ovf_q;
  assign stat_seq_err   = stat_seq_q;
  assign bad_count      = bad_count_q;
  assign ovf_count      = ovf_count_q;
  assign seq_err_count  = seq_count_q;

endmodule

// File: tb/tb_eth_phy_ipg_rx_extract.sv
// Bench for eth_phy_ipg_rx_extract: directed scenarios plus random traffic against a byte-queue model.
module tb_eth_phy_ipg_rx_extract;
  localparam int OB    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   in_data = '0;
  logic [1:0]    in_hdr = '0;
  logic          in_valid = 1'b0;
  logic          rx_block_lock = 1'b0;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic          stat_ipg_block, stat_bad_block, stat_overflow, stat_seq_err;
  logic [CW-1:0] bad_count, ovf_count, seq_err_count;

  always #5 clk = ~clk;

  eth_phy_ipg_rx_extract #(.OUT_BYTES(OB), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
    .rx_block_lock(rx_block_lock), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .stat_ipg_block(stat_ipg_block),
    .stat_bad_block(stat_bad_block), .stat_overflow(stat_overflow), .stat_seq_err(stat_seq_err),
    .bad_count(bad_count), .ovf_count(ovf_count), .seq_err_count(seq_err_count));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte queue accumulator, word queue with visibility time for the head
  typedef struct { logic [63:0] d; logic [7:0] k; logic l; } wrd_t;
  wrd_t       fq[$];
  logic [7:0] acc[$];
  int         head_avail = 0;
  int         edge_n = 0;
  logic       e_ipg, e_bad, e_ovf, e_seq;
  int         e_badc, e_ovfc, e_seqc;
  bit         armed;
  logic [4:0] exp_seq;

  function automatic void model_reset();
    fq.delete(); acc.delete();
    e_ipg = 0; e_bad = 0; e_ovf = 0; e_seq = 0;
    e_badc = 0; e_ovfc = 0; e_seqc = 0;
    armed = 0; exp_seq = '0;
  endfunction

  function automatic void model_edge(input logic v, input logic [1:0] h, input logic [63:0] d,
                                     input logic lk, input logic rdy);
    bit pop, full, do_push;
    wrd_t w;
    int nb;
    edge_n++;
    pop  = (fq.size() > 0) && (head_avail <= edge_n - 1) && rdy;
    full = fq.size() == DEPTH;
    e_ipg = 0; e_bad = 0; e_ovf = 0; e_seq = 0;
    do_push = 0;
    w.d = '0; w.k = '0; w.l = 1'b0;
    if (!lk) begin
      acc.delete();
      armed = 0;
    end else if (v) begin
      if (h == 2'b01 && d[7:0] == 8'hD2) begin
        nb = int'(d[10:8]);
        if (nb > 6) begin
          e_bad = 1;
          if (e_badc < CMAX) e_badc++;
        end else begin
          e_ipg = 1;
`ifdef IPG_SEQ_CHECK_EN
          if (armed && d[15:11] != exp_seq) begin
            e_seq = 1;
            if (e_seqc < CMAX) e_seqc++;
          end
          armed = 1;
          exp_seq = d[15:11] + 5'd1;
`endif
          if (acc.size() + nb >= OB && full && !pop) begin
            e_ovf = 1;
            if (e_ovfc < CMAX) e_ovfc++;
          end else begin
            for (int k = 0; k < nb; k++) acc.push_back(d[16+8*k +: 8]);
            if (acc.size() >= OB) begin
              w.k = '1;
              for (int i = 0; i < OB; i++) w.d[8*i +: 8] = acc.pop_front();
              do_push = 1;
            end
          end
        end
      end else if ((h == 2'b10 || h == 2'b01) && acc.size() > 0) begin
        if (full && !pop) begin
          e_ovf = 1;
          if (e_ovfc < CMAX) e_ovfc++;
        end else begin
          w.l = 1'b1;
          for (int i = 0; i < acc.size(); i++) begin
            w.d[8*i +: 8] = acc[i];
            w.k[i] = 1'b1;
          end
          do_push = 1;
        end
        acc.delete();
      end
    end
    if (pop) begin
      void'(fq.pop_front());
      head_avail = edge_n;
    end
    if (do_push) begin
      fq.push_back(w);
      if (fq.size() == 1) head_avail = edge_n + 1;
    end
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (fq.size() > 0) && (head_avail <= edge_n);
    check("tvalid", 64'(m_tvalid), 64'(ev));
    if (ev) begin
      check("tdata", m_tdata, fq[0].d);
      check("tkeep", 64'(m_tkeep), 64'(fq[0].k));
      check("tlast", 64'(m_tlast), 64'(fq[0].l));
    end
    check("stat_ipg", 64'(stat_ipg_block), 64'(e_ipg));
    check("stat_bad", 64'(stat_bad_block), 64'(e_bad));
    check("stat_ovf", 64'(stat_overflow), 64'(e_ovf));
    check("stat_seq", 64'(stat_seq_err), 64'(e_seq));
    check("bad_count", 64'(bad_count), 64'(e_badc));
    check("ovf_count", 64'(ovf_count), 64'(e_ovfc));
    check("seq_count", 64'(seq_err_count), 64'(e_seqc));
  endtask

  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d,
                      input logic lk, input logic rdy);
    in_valid = v; in_hdr = h; in_data = d; rx_block_lock = lk; m_tready = rdy;
    @(posedge clk);
    model_edge(v, h, d, lk, rdy);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, 64'h0, 1'b1, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; m_tready = 1'b0;
    @(posedge clk);
    edge_n++;
    model_reset();
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_tdata", m_tdata, 64'h0);
    check("rst_tkeep", 64'(m_tkeep), 64'h0);
    check("rst_tlast", 64'(m_tlast), 64'h0);
    check("rst_stats", 64'({stat_ipg_block, stat_bad_block, stat_overflow, stat_seq_err}), 64'h0);
    check("rst_counts", 64'({bad_count, ovf_count, seq_err_count}), 64'h0);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] carrier(input int n, input int seq, input logic [7:0] b0);
    logic [63:0] r;
    r = '0;
    r[7:0]   = 8'hD2;
    r[10:8]  = 3'(n);
    r[15:11] = 5'(seq);
    for (int k = 0; k < 6; k++) r[16+8*k +: 8] = b0 + 8'(k);
    return r;
  endfunction

  initial begin
    int r, seq;
    logic [63:0] d;
    logic [1:0] h;
    m_tready = 1'b0;
    do_reset();

    // Two six-byte carriers make one full word, then a data block flushes the rest
    step(1'b1, 2'b01, carrier(6, 0, 8'h01), 1'b1, 1'b0);
    step(1'b1, 2'b01, carrier(6, 1, 8'h07), 1'b1, 1'b0);
    idle(1'b0);
    check("t1_data", m_tdata, 64'h0807060504030201);
    check("t1_keep", 64'(m_tkeep), 64'hFF);
    check("t1_last", 64'(m_tlast), 64'h0);
    step(1'b1, 2'b10, 64'h0, 1'b1, 1'b0);
    idle(1'b1);
    check("t2_data", m_tdata, 64'h000000000C0B0A09);
    check("t2_keep", 64'(m_tkeep), 64'h0F);
    check("t2_last", 64'(m_tlast), 64'h1);
    idle(1'b1);

    // Malformed block with a partial word held, then N=0 and a flush via a non-carrier control
    step(1'b1, 2'b01, carrier(3, 2, 8'h21), 1'b1, 1'b1);
    step(1'b1, 2'b01, carrier(7, 3, 8'h31), 1'b1, 1'b1);
    check("t3_bad_pulse", 64'(stat_bad_block), 64'h1);
    check("t3_bad_count", 64'(bad_count), 64'h1);
    step(1'b1, 2'b01, carrier(0, 4, 8'h41), 1'b1, 1'b1);
    check("t3_pulse_end", 64'(stat_bad_block), 64'h0);
    step(1'b1, 2'b01, 64'h0000_0000_0000_001E, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 2'b01, carrier(7, i, 8'h00), 1'b1, 1'b1);
    check("sat_bad_count", 64'(bad_count), 64'(CMAX));

    // Sequence gap
    do_reset();
    step(1'b1, 2'b01, carrier(1, 3, 8'h50), 1'b1, 1'b1);
    step(1'b1, 2'b01, carrier(1, 4, 8'h51), 1'b1, 1'b1);
    step(1'b1, 2'b01, carrier(1, 6, 8'h52), 1'b1, 1'b1);
`ifdef IPG_SEQ_CHECK_EN
    check("t5_seq_pulse", 64'(stat_seq_err), 64'h1);
`else
    check("t5_seq_pulse", 64'(stat_seq_err), 64'h0);
`endif
    step(1'b1, 2'b01, carrier(1, 7, 8'h53), 1'b1, 1'b1);
    check("t5_seq_none", 64'(stat_seq_err), 64'h0);
`ifdef IPG_SEQ_CHECK_EN
    check("t5_seq_count", 64'(seq_err_count), 64'h1);
`else
    check("t5_seq_count", 64'(seq_err_count), 64'h0);
`endif

    // Overflow with a stalled consumer, then drain
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 2'b01, carrier(6, i, 8'(8'h10 * i)), 1'b1, 1'b0);
    check("t4_ovf_pulse", 64'(stat_overflow), 64'h1);
    check("t4_ovf_count", 64'(ovf_count), 64'h1);
    repeat (6) idle(1'b1);
    check("t4_drained", 64'(m_tvalid), 64'h0);

    // Lock loss mid-burst discards the partial word; reset mid-drain clears outputs
    do_reset();
    step(1'b1, 2'b01, carrier(3, 0, 8'hA0), 1'b1, 1'b1);
    step(1'b1, 2'b00, 64'h0, 1'b0, 1'b1);
    step(1'b1, 2'b10, 64'h0, 1'b1, 1'b1);
    idle(1'b1);
    check("t6_no_tlast", 64'(m_tvalid), 64'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, carrier(6, i, 8'hB0), 1'b1, 1'b0);
    idle(1'b1);
    do_reset();

    // Random traffic
    seq = 0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      d = {$urandom, $urandom};
      if (r < 55) begin
        h = 2'b01;
        seq = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : (seq + 1) % 32;
        d = carrier(($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6), seq, 8'($urandom));
      end else if (r < 75) begin
        h = 2'b10;
      end else if (r < 88) begin
        h = 2'b01;
        d[7:0] = 8'h1E;
      end else begin
        h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      end
      step(1'($urandom_range(0, 9) != 0), h, d, 1'($urandom_range(0, 39) != 0),
           1'($urandom_range(0, 9) < 6));
    end
    repeat (8) idle(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
